// File: rtl/conv2d_patch_feeder.sv
// Streams a raster image and emits 3x3x3 stride-2, pad-1 convolution patches.
// Two line buffers hold the previous rows; a small tap window holds the two previous columns.
module conv2d_patch_feeder #(
    parameter int bitsize = 18,
    parameter int IMG_W   = 224,
    parameter int IMG_H   = 224
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    input  logic [3*bitsize-1:0]          pix_in,
    output logic [27*bitsize-1:0]         data_out,
    output logic                          start_flag,
    output logic [$clog2(IMG_H/2)-1:0]    out_row,
    output logic [$clog2(IMG_W/2)-1:0]    out_col,
    output logic                          frame_done
);

    localparam int PW  = 3 * bitsize;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] r_q, r_d;

    logic [PW-1:0] lb0_q [IMG_W];
    logic [PW-1:0] lb1_q [IMG_W];
    logic [PW-1:0] win_q [3][2];

    logic [PW-1:0]       col_new [3];
    logic [PW-1:0]       tap     [3][3];
    logic [27*bitsize-1:0] patch;
    logic                accept;
    logic                trigger;
    logic                pad_top;
    logic                pad_left;
    logic                last_patch;

    assign accept     = pix_valid && !rst;
    assign trigger    = accept && r_q[0] && c_q[0];
    assign pad_top    = (r_q == RW'(1));
    assign pad_left   = (c_q == CW'(1));
    assign last_patch = (r_q == R_LAST) && (c_q == C_LAST);

    // Newest column of the window: rows r-2, r-1 from the line buffers, row r live.
    assign col_new[0] = lb1_q[c_q];
    assign col_new[1] = lb0_q[c_q];
    assign col_new[2] = pix_in;

    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (accept) begin
            if (c_q == C_LAST) begin
                c_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    always_comb begin
        for (int ky = 0; ky < 3; ky++) begin
            tap[ky][0] = win_q[ky][0];
            tap[ky][1] = win_q[ky][1];
            tap[ky][2] = col_new[ky];
        end
    end

    // Padding overrides whatever stale data sits in the buffers from a previous row or frame.
    always_comb begin
        patch = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                if (!((ky == 0 && pad_top) || (kx == 0 && pad_left))) begin
                    patch[(ky*3+kx)*PW +: PW] = tap[ky][kx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[c_q] <= lb0_q[c_q];
            lb0_q[c_q] <= pix_in;
            for (int ky = 0; ky < 3; ky++) begin
                win_q[ky][0] <= win_q[ky][1];
                win_q[ky][1] <= col_new[ky];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q        <= '0;
            r_q        <= '0;
            data_out   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            start_flag <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            c_q        <= c_d;
            r_q        <= r_d;
            start_flag <= trigger;
            frame_done <= trigger && last_patch;
            if (trigger) begin
                data_out <= patch;
                out_row  <= r_q[RW-1:1];
                out_col  <= c_q[CW-1:1];
            end
        end
    end

endmodule

// File: tb/tb_conv2d_patch_feeder.sv
// Checks conv2d_patch_feeder against an image-array reference model (4x4 and 224x224 builds).
module tb_conv2d_patch_feeder;

    localparam int B  = 18;
    localparam int PW = 3 * B;
    localparam int DW = 27 * B;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic [PW-1:0] pix_in;

    logic [DW-1:0] d4, d224;
    logic          sf4, sf224, fd4, fd224;
    logic [0:0]    row4, col4;
    logic [6:0]    row224, col224;

    always #5 clk = ~clk;

    conv2d_patch_feeder #(.bitsize(B), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in),
        .data_out(d4), .start_flag(sf4), .out_row(row4), .out_col(col4), .frame_done(fd4));

    conv2d_patch_feeder #(.bitsize(B), .IMG_W(224), .IMG_H(224)) u_dut224 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in),
        .data_out(d224), .start_flag(sf224), .out_row(row224), .out_col(col224), .frame_done(fd224));

    logic          sel;
    logic [DW-1:0] mon_data;
    logic          mon_sf, mon_fd;
    logic [6:0]    mon_row, mon_col;

    assign mon_data = sel ? d224 : d4;
    assign mon_sf   = sel ? sf224 : sf4;
    assign mon_fd   = sel ? fd224 : fd4;
    assign mon_row  = sel ? row224 : {6'd0, row4};
    assign mon_col  = sel ? col224 : {6'd0, col4};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [PW-1:0] img [224][224];
    logic [PW-1:0] src [224][224];
    int            cur_w, cur_h;
    int            rm, cm;
    logic [DW-1:0] exp_data;
    logic [6:0]    exp_row, exp_col;
    logic          exp_sf, exp_fd;

    logic [DW-1:0] got[$];
    int            pulse_cyc[$];
    int            cyc_since;
    int            n_fd;

    function automatic logic [DW-1:0] ref_patch(input int r, input int c);
        logic [DW-1:0] res;
        logic [PW-1:0] p;
        res = '0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                int y, x;
                y = r - 2 + ky;
                x = c - 2 + kx;
                p = (y >= 0 && x >= 0) ? img[y][x] : '0;
                for (int ch = 0; ch < 3; ch++)
                    res[((ky*3+kx)*3+ch)*B +: B] = p[ch*B +: B];
            end
        return res;
    endfunction

    function automatic logic [B-1:0] elem(input logic [DW-1:0] p, input int ky, input int kx, input int ch);
        return p[((ky*3+kx)*3+ch)*B +: B];
    endfunction

    task automatic step(input logic v, input logic [PW-1:0] px);
        rst       = 1'b0;
        pix_valid = v;
        pix_in    = px;
        exp_sf    = 1'b0;
        exp_fd    = 1'b0;
        if (v) begin
            img[rm][cm] = px;
            if (rm % 2 == 1 && cm % 2 == 1) begin
                exp_sf   = 1'b1;
                exp_data = ref_patch(rm, cm);
                exp_row  = 7'((rm - 1) / 2);
                exp_col  = 7'((cm - 1) / 2);
                exp_fd   = (rm == cur_h - 1) && (cm == cur_w - 1);
            end
            if (cm == cur_w - 1) begin
                cm = 0;
                rm = (rm == cur_h - 1) ? 0 : rm + 1;
            end else begin
                cm++;
            end
        end
        @(posedge clk);
        #1;
        cyc_since++;
        check("start_flag", DW'(mon_sf), DW'(exp_sf));
        check("frame_done", DW'(mon_fd), DW'(exp_fd));
        check("data_out", mon_data, exp_data);
        check("out_row", DW'(mon_row), DW'(exp_row));
        check("out_col", DW'(mon_col), DW'(exp_col));
        if (mon_sf) begin
            got.push_back(mon_data);
            pulse_cyc.push_back(cyc_since + 1);
        end
        if (mon_fd) n_fd++;
    endtask

    task automatic do_reset(input logic v);
        rst       = 1'b1;
        pix_valid = v;
        pix_in    = PW'({$urandom, $urandom});
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rm       = 0;
        cm       = 0;
        exp_data = '0;
        exp_row  = '0;
        exp_col  = '0;
        check("rst_start_flag", DW'(mon_sf), '0);
        check("rst_frame_done", DW'(mon_fd), '0);
        check("rst_data_out", mon_data, '0);
        check("rst_out_row", DW'(mon_row), '0);
        check("rst_out_col", DW'(mon_col), '0);
    endtask

    task automatic clear_log();
        got.delete();
        pulse_cyc.delete();
        cyc_since = 0;
        n_fd      = 0;
    endtask

    task automatic fill_src(input bit pattern);
        for (int r = 0; r < cur_h; r++)
            for (int c = 0; c < cur_w; c++)
                for (int ch = 0; ch < 3; ch++)
                    src[r][c][ch*B +: B] = pattern ? B'(16*ch + 4*r + c) : B'($urandom);
    endtask

    // gap_mode: 0 continuous, 1 idle cycle before every pixel, 2 random idle cycles
    task automatic send_pixels(input int count, input int gap_mode);
        int r, c;
        r = rm;
        c = cm;
        for (int i = 0; i < count; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))
                step(1'b0, PW'({$urandom, $urandom}));
            step(1'b1, src[r][c]);
            if (c == cur_w - 1) begin
                c = 0;
                r = (r == cur_h - 1) ? 0 : r + 1;
            end else begin
                c++;
            end
        end
    endtask

    logic [DW-1:0] ref_q[$];

    initial begin
        sel       = 1'b0;
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;
        cur_w     = 4;
        cur_h     = 4;
        rm        = 0;
        cm        = 0;
        exp_data  = '0;
        exp_row   = '0;
        exp_col   = '0;
        cyc_since = 0;
        n_fd      = 0;
        @(posedge clk);
        do_reset(1'b1);

        // Continuous 4x4 pattern frame
        fill_src(1'b1);
        clear_log();
        send_pixels(16, 0);
        step(1'b0, '0);
        check("n_pulses", DW'(got.size()), DW'(4));
        check("pulse0_cycle", DW'(pulse_cyc[0]), DW'(7));
        check("pulse1_cycle", DW'(pulse_cyc[1]), DW'(9));
        check("pulse2_cycle", DW'(pulse_cyc[2]), DW'(15));
        check("pulse3_cycle", DW'(pulse_cyc[3]), DW'(17));
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < 3; ch++) begin
                check("p00_top_pad", DW'(elem(got[0], 0, k, ch)), '0);
                check("p00_left_pad", DW'(elem(got[0], k, 0, ch)), '0);
            end
        end
        check("p00_e110", DW'(elem(got[0], 1, 1, 0)), DW'(0));
        check("p00_e222", DW'(elem(got[0], 2, 2, 2)), DW'(37));
        check("p11_e000", DW'(elem(got[3], 0, 0, 0)), DW'(5));
        check("p11_e220", DW'(elem(got[3], 2, 2, 0)), DW'(15));
        check("p11_e111", DW'(elem(got[3], 1, 1, 1)), DW'(26));
        check("n_frame_done", DW'(n_fd), DW'(1));
        ref_q = got;

        // Same image, pixel every other cycle
        do_reset(1'b0);
        clear_log();
        send_pixels(16, 1);
        step(1'b0, '0);
        step(1'b0, '0);
        check("gap_n_pulses", DW'(got.size()), DW'(4));
        for (int i = 0; i < 4; i++) check("gap_patch", got[i], ref_q[i]);

        // Two back-to-back random frames
        do_reset(1'b0);
        fill_src(1'b0);
        clear_log();
        send_pixels(32, 0);
        step(1'b0, '0);
        check("b2b_n_pulses", DW'(got.size()), DW'(8));
        for (int i = 0; i < 4; i++) check("b2b_frame2", got[i+4], got[i]);
        check("b2b_n_frame_done", DW'(n_fd), DW'(2));

        // Abort after 9 pixels, then a full frame
        do_reset(1'b0);
        fill_src(1'b0);
        send_pixels(9, 0);
        do_reset(1'b1);
        clear_log();
        step(1'b0, '0);
        check("abort_no_pending", DW'(got.size()), '0);
        fill_src(1'b0);
        send_pixels(16, 0);
        step(1'b0, '0);
        check("abort_next_pulses", DW'(got.size()), DW'(4));

        // Reset right after a patch-producing pixel suppresses nothing stale afterwards
        fill_src(1'b0);
        send_pixels(6, 0);
        do_reset(1'b1);
        clear_log();
        step(1'b0, '0);
        check("pending_cleared", DW'(got.size()), '0);

        // Random data and random gaps, three frames
        for (int f = 0; f < 3; f++) begin
            fill_src(1'b0);
            clear_log();
            send_pixels(16, 2);
            step(1'b0, '0);
            check("rand_n_pulses", DW'(got.size()), DW'(4));
        end

        // Full 224x224 frame
        sel   = 1'b1;
        cur_w = 224;
        cur_h = 224;
        do_reset(1'b0);
        fill_src(1'b0);
        clear_log();
        send_pixels(224 * 224, 0);
        step(1'b0, '0);
        check("big_n_pulses", DW'(got.size()), DW'(12544));
        check("big_n_frame_done", DW'(n_fd), DW'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
